// File: rtl/sequence_generator_if.sv
// Request/stream bundle between a frame requester and the sequence generator.
// Purely structural: carries start/pattern/repeat_count in and the serial stream out.
// No flow control; the requester watches busy/done.
`timescale 1ns/1ps
interface sequence_generator_if #(
    parameter int SEQ_LEN = 4
) ();
    logic               start;
    logic [SEQ_LEN-1:0] pattern;
    logic [2:0]         repeat_count;
    logic               data_out;
    logic               valid;
    logic               busy;
    logic               done;
    logic [2:0]         state_out;

    // requester side
    modport master (
        output start, pattern, repeat_count,
        input  data_out, valid, busy, done, state_out
    );

    // generator side
    modport slave (
        input  start, pattern, repeat_count,
        output data_out, valid, busy, done, state_out
    );
endinterface

// File: rtl/sequence_generator.sv
// Serializes a latched pattern MSB first, repeat_count+1 frames back-to-back, then pulses done.
// Latency: first valid bit one cycle after start is accepted; each bit held CYCLES_PER_BIT cycles.
// No backpressure: start is only sampled in IDLE and is dropped (not queued) while busy.
`timescale 1ns/1ps
module sequence_generator #(
    parameter int SEQ_LEN        = 4,
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_generator_if.slave  bus
);
    localparam int               IDX_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(SEQ_LEN - 1);
    localparam logic [3:0]       HOLD_MAX  = 4'(CYCLES_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        DONE = 3'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEQ_LEN-1:0] pat_q, pat_d;
    logic [2:0]         frames_q, frames_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         hold_q, hold_d;

    // State and datapath registers; reset clears everything including the latched frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            frames_q <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            frames_q <= frames_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state / next-counter logic. The bit index counts down so pat_q[idx_q] is MSB first.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        frames_d = frames_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SEND;
                    pat_d    = bus.pattern;
                    frames_d = bus.repeat_count;
                    idx_d    = FIRST_IDX;
                    hold_d   = '0;
                end
            end
            SEND: begin
                if (hold_q == HOLD_MAX) begin
                    hold_d = '0;
                    if (idx_q == '0) begin
                        if (frames_q == '0) begin
                            state_d = DONE;
                        end else begin
                            // wrap straight into the next frame with no gap cycle
                            frames_d = frames_q - 3'd1;
                            idx_d    = FIRST_IDX;
                        end
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs: decoded from registered state and counters only.
    always_comb begin
        bus.valid     = 1'b0;
        bus.data_out  = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.state_out = state_q;
        if (state_q == SEND) begin
            bus.valid    = 1'b1;
            bus.data_out = pat_q[idx_q];
        end
        if (state_q == DONE) begin
            bus.done = 1'b1;
        end
    end
endmodule

// File: tb/tb_sequence_generator.sv
`timescale 1ns/1ps
module tb_sequence_generator;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sequence_generator_if #(.SEQ_LEN(4)) bus_a ();
    sequence_generator_if #(.SEQ_LEN(4)) bus_b ();

    sequence_generator #(.SEQ_LEN(4), .CYCLES_PER_BIT(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sequence_generator #(.SEQ_LEN(4), .CYCLES_PER_BIT(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs_a, obs_b;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            obs_a = {bus_a.data_out, bus_a.valid, bus_a.busy, bus_a.done, bus_a.state_out};
            obs_b = {bus_b.data_out, bus_b.valid, bus_b.busy, bus_b.done, bus_b.state_out};
            total++;
            if (obs_a !== 7'b0) begin
                bad++;
                $display("FAIL reset_idle_a cyc=%0d got=%b exp=%b", i, obs_a, 7'b0);
            end
            total++;
            if (obs_b !== 7'b0) begin
                bad++;
                $display("FAIL reset_idle_b cyc=%0d got=%b exp=%b", i, obs_b, 7'b0);
            end
            tick();
        end
    endtask

    task automatic test_single();
        // {data_out, valid, busy, done, state_out} for cycles 1..6
        logic [6:0] exp_tab [6];
        logic [6:0] obs;
        exp_tab = '{7'b1_1_1_0_001, 7'b0_1_1_0_001, 7'b1_1_1_0_001,
                    7'b0_1_1_0_001, 7'b0_0_1_1_010, 7'b0_0_0_0_000};
        bus_a.start        = 1'b1;
        bus_a.pattern      = 4'b1010;
        bus_a.repeat_count = 3'd0;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            obs = {bus_a.data_out, bus_a.valid, bus_a.busy, bus_a.done, bus_a.state_out};
            total++;
            if (obs !== exp_tab[i]) begin
                bad++;
                $display("FAIL single_frame cyc=%0d got=%b exp=%b", i + 1, obs, exp_tab[i]);
            end
            tick();
        end
    endtask

    task automatic test_repeat();
        logic [11:0] exp_bits;
        exp_bits = 12'b101010101010;
        bus_a.start        = 1'b1;
        bus_a.pattern      = 4'b1010;
        bus_a.repeat_count = 3'd2;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if ({bus_a.valid, bus_a.data_out, bus_a.done} !== {1'b1, exp_bits[11-i], 1'b0}) begin
                bad++;
                $display("FAIL repeat_bits cyc=%0d got v=%b d=%b done=%b exp v=1 d=%b done=0",
                         i + 1, bus_a.valid, bus_a.data_out, bus_a.done, exp_bits[11-i]);
            end
            tick();
        end
        total++;
        if ({bus_a.done, bus_a.valid, bus_a.state_out} !== {1'b1, 1'b0, 3'd2}) begin
            bad++;
            $display("FAIL repeat_done got done=%b v=%b st=%0d exp done=1 v=0 st=2",
                     bus_a.done, bus_a.valid, bus_a.state_out);
        end
        tick();
        total++;
        if ({bus_a.done, bus_a.busy, bus_a.state_out} !== 5'b0) begin
            bad++;
            $display("FAIL repeat_idle got done=%b busy=%b st=%0d exp all 0",
                     bus_a.done, bus_a.busy, bus_a.state_out);
        end
    endtask

    task automatic test_hold();
        logic [11:0] exp_bits;
        exp_bits = 12'b111111000000;
        bus_b.start        = 1'b1;
        bus_b.pattern      = 4'b1100;
        bus_b.repeat_count = 3'd0;
        tick();
        bus_b.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            total++;
            if ({bus_b.valid, bus_b.data_out} !== {1'b1, exp_bits[11-i]}) begin
                bad++;
                $display("FAIL hold_bits cyc=%0d got v=%b d=%b exp v=1 d=%b",
                         i + 1, bus_b.valid, bus_b.data_out, exp_bits[11-i]);
            end
            tick();
        end
        total++;
        if ({bus_b.done, bus_b.valid, bus_b.state_out} !== {1'b1, 1'b0, 3'd2}) begin
            bad++;
            $display("FAIL hold_done got done=%b v=%b st=%0d exp done=1 v=0 st=2",
                     bus_b.done, bus_b.valid, bus_b.state_out);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int         vcnt;
        int         dcnt;
        logic [3:0] bits;
        vcnt = 0;
        dcnt = 0;
        bits = '0;
        bus_a.start        = 1'b1;
        bus_a.pattern      = 4'b1010;
        bus_a.repeat_count = 3'd0;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus_a.valid === 1'b1) begin
                vcnt++;
                bits = {bits[2:0], bus_a.data_out};
            end
            if (bus_a.done === 1'b1) dcnt++;
            if (i == 1) begin
                bus_a.start   = 1'b1;
                bus_a.pattern = 4'b0110;
            end
            if (i == 2) bus_a.start = 1'b0;
            tick();
        end
        total++;
        if (bits !== 4'b1010) begin
            bad++;
            $display("FAIL ignore_bits got=%b exp=1010", bits);
        end
        total++;
        if (vcnt != 4) begin
            bad++;
            $display("FAIL ignore_valid_count got=%0d exp=4", vcnt);
        end
        total++;
        if (dcnt != 1) begin
            bad++;
            $display("FAIL ignore_done_count got=%0d exp=1", dcnt);
        end
        total++;
        if (bus_a.busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_busy_after got=%b exp=0", bus_a.busy);
        end
    endtask

    task automatic test_reset_abort();
        logic [6:0] obs;
        logic [3:0] exp_bits;
        int         dcnt;
        exp_bits = 4'b1010;
        dcnt     = 0;
        bus_a.start        = 1'b1;
        bus_a.pattern      = 4'b1010;
        bus_a.repeat_count = 3'd0;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
        total++;
        if ({bus_a.valid, bus_a.data_out} !== 2'b11) begin
            bad++;
            $display("FAIL abort_third_bit got v=%b d=%b exp v=1 d=1", bus_a.valid, bus_a.data_out);
        end
        reset = 1'b1;
        tick();
        obs = {bus_a.data_out, bus_a.valid, bus_a.busy, bus_a.done, bus_a.state_out};
        total++;
        if (obs !== 7'b0) begin
            bad++;
            $display("FAIL abort_outputs got=%b exp=%b", obs, 7'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus_a.done === 1'b1 || bus_a.busy === 1'b1) dcnt++;
            tick();
        end
        total++;
        if (dcnt != 0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d active cycles exp=0", dcnt);
        end
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus_a.valid, bus_a.data_out} !== {1'b1, exp_bits[3-i]}) begin
                bad++;
                $display("FAIL abort_restart cyc=%0d got v=%b d=%b exp v=1 d=%b",
                         i + 1, bus_a.valid, bus_a.data_out, exp_bits[3-i]);
            end
            tick();
        end
        total++;
        if (bus_a.done !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart_done got=%b exp=1", bus_a.done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_bits;
        exp_bits = 4'b1001;
        bus_a.start        = 1'b1;
        bus_a.pattern      = 4'b0011;
        bus_a.repeat_count = 3'd0;
        tick();
        bus_a.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        // cycle 5: DONE; raise start now and hold it into the following IDLE cycle
        total++;
        if (bus_a.done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done got=%b exp=1", bus_a.done);
        end
        bus_a.start   = 1'b1;
        bus_a.pattern = 4'b1001;
        tick();
        total++;
        if (bus_a.state_out !== 3'd0) begin
            bad++;
            $display("FAIL b2b_idle_after_done got=%0d exp=0", bus_a.state_out);
        end
        tick();
        bus_a.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus_a.valid, bus_a.data_out} !== {1'b1, exp_bits[3-i]}) begin
                bad++;
                $display("FAIL b2b_bits cyc=%0d got v=%b d=%b exp v=1 d=%b",
                         i + 1, bus_a.valid, bus_a.data_out, exp_bits[3-i]);
            end
            tick();
        end
        total++;
        if (bus_a.done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_done got=%b exp=1", bus_a.done);
        end
        tick();
    endtask

    initial begin
        bus_a.start        = 1'b0;
        bus_a.pattern      = '0;
        bus_a.repeat_count = '0;
        bus_b.start        = 1'b0;
        bus_b.pattern      = '0;
        bus_b.repeat_count = '0;
        #1;
        test_reset();
        test_single();
        test_repeat();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
